// File: rtl/defunnel.sv
// Gathers CHUNK_W-bit beats from up to CHUNKS/2 lanes into one CHUNKS*CHUNK_W-bit word.
// The optional sticky protocol-error flag is built only when DEFUNNEL_ERR_EN is defined.
module defunnel #(
    parameter  int CHUNKS  = 8,
    parameter  int CHUNK_W = 128,
    localparam int STEPS   = $clog2(CHUNKS),
    localparam int LANES   = CHUNKS / 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [LANES-1:0]            t_req,
    output logic [LANES-1:0]            t_ack,
    input  logic [LANES*CHUNK_W-1:0]    t_dat,
    input  logic                        t_cfg_req,
    output logic                        t_cfg_ack,
    input  logic [7:0]                  mode,
    output logic                        i_0_req,
    input  logic                        i_0_ack,
    output logic [CHUNKS*CHUNK_W-1:0]   i_0_dat,
    output logic                        err,
    output logic [STEPS-1:0]            dbg_state_o,
    output logic [STEPS-1:0]            dbg_reduct_o
);

    // Handshakes: a transfer happens on a rising clk edge where both req and ack are high.
    // t_ack / t_cfg_ack are combinational from registered state and the current requests.

    logic [STEPS-1:0]          state_q, state_d;
    logic [STEPS-1:0]          reduct_q, reduct_d;
    logic                      req_q, req_d;
    logic [CHUNKS*CHUNK_W-1:0] dat_q, dat_d;
    logic [CHUNKS*CHUNK_W-1:0] asm_q, asm_d;

    logic [LANES-1:0] active;
    logic [STEPS-1:0] state_nxt;
    logic             can_take;
    logic             fire;
    logic             last;
    logic             cfg_hs;
    logic             mode_legal;
    logic             unused_mode;

    assign unused_mode = ^mode;

    always_comb begin
        active = '0;
        // reduct is one-hot, so its value is also the active lane count
        for (int j = 0; j < LANES; j++) begin
            active[j] = (STEPS'(j) < reduct_q);
        end
    end

    assign can_take   = ~req_q | i_0_ack;
    assign fire       = can_take & ((t_req & active) == active);
    assign t_ack      = fire ? active : '0;
    assign state_nxt  = state_q + reduct_q;
    assign last       = (state_nxt == '0);
    assign t_cfg_ack  = (state_q == '0) & ~req_q;
    assign cfg_hs     = t_cfg_req & t_cfg_ack;
    assign mode_legal = $onehot(mode[STEPS-1:0]);

    always_comb begin
        asm_d = asm_q;
        // state is a multiple of the lane count, so lane j lands on chunk state + j
        for (int j = 0; j < LANES; j++) begin
            if (fire && active[j]) begin
                asm_d[(int'(state_q) + j)*CHUNK_W +: CHUNK_W] = t_dat[j*CHUNK_W +: CHUNK_W];
            end
        end
    end

    always_comb begin
        state_d  = fire ? state_nxt : state_q;
        reduct_d = (cfg_hs && mode_legal) ? mode[STEPS-1:0] : reduct_q;
        req_d    = req_q;
        dat_d    = dat_q;
        if (fire && last) begin
            req_d = 1'b1;
            dat_d = asm_d;
        end else if (i_0_ack) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= '0;
            reduct_q <= STEPS'(1) << (STEPS-1);
            req_q    <= 1'b0;
            dat_q    <= '0;
            asm_q    <= '0;
        end else begin
            state_q  <= state_d;
            reduct_q <= reduct_d;
            req_q    <= req_d;
            dat_q    <= dat_d;
            asm_q    <= asm_d;
        end
    end

`ifdef DEFUNNEL_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((cfg_hs && !mode_legal) || ((t_req & ~active) != '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign i_0_req      = req_q;
    assign i_0_dat      = dat_q;
    assign dbg_state_o  = state_q;
    assign dbg_reduct_o = reduct_q;

endmodule

// File: tb/tb_defunnel.sv
// Bench for defunnel: directed scenarios plus random traffic against a chunk-list reference model.
module tb_defunnel;

  localparam int CHUNKS  = 8;
  localparam int CHUNK_W = 128;
  localparam int LANES   = 4;
  localparam int STEPS   = 3;
  localparam int DW      = CHUNKS * CHUNK_W;
  localparam int TW      = LANES * CHUNK_W;

  // clock/reset block
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [LANES-1:0] t_req;
  logic [LANES-1:0] t_ack;
  logic [TW-1:0]    t_dat;
  logic             t_cfg_req;
  logic             t_cfg_ack;
  logic [7:0]       mode;
  logic             i_0_req;
  logic             i_0_ack;
  logic [DW-1:0]    i_0_dat;
  logic             err;
  logic [STEPS-1:0] dbg_state_o;
  logic [STEPS-1:0] dbg_reduct_o;

  defunnel #(.CHUNKS(CHUNKS), .CHUNK_W(CHUNK_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .t_req(t_req), .t_ack(t_ack), .t_dat(t_dat),
    .t_cfg_req(t_cfg_req), .t_cfg_ack(t_cfg_ack), .mode(mode),
    .i_0_req(i_0_req), .i_0_ack(i_0_ack), .i_0_dat(i_0_dat),
    .err(err), .dbg_state_o(dbg_state_o), .dbg_reduct_o(dbg_reduct_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: chunks collected so far, lane count, pending output words
  int               m_lanes;
  int               m_count;
  bit               m_out_valid;
  bit               m_err;
  logic [CHUNK_W-1:0] m_chunks[CHUNKS];
  logic [DW-1:0]    exp_q[$];

  task automatic model_reset();
    m_lanes = LANES;
    m_count = 0;
    m_out_valid = 0;
    m_err = 0;
    exp_q.delete();
  endtask

  function automatic logic [LANES-1:0] lane_mask(input int n);
    logic [LANES-1:0] m;
    m = '0;
    for (int j = 0; j < n; j++) m[j] = 1'b1;
    return m;
  endfunction

  function automatic logic [DW-1:0] seq_word();
    logic [DW-1:0] w;
    for (int n = 0; n < CHUNKS; n++) w[n*CHUNK_W +: CHUNK_W] = CHUNK_W'(n);
    return w;
  endfunction

  function automatic bit legal_mode(input logic [7:0] md);
    logic [STEPS-1:0] low;
    low = md[STEPS-1:0];
    return (low == 1) || (low == 2) || (low == 4);
  endfunction

  // driver tasks
  task automatic set_lane(input int j, input logic [CHUNK_W-1:0] v);
    t_dat[j*CHUNK_W +: CHUNK_W] = v;
  endtask

  task automatic set_beat(input logic [LANES-1:0] req, input int first_val);
    t_req = req;
    for (int j = 0; j < LANES; j++) set_lane(j, CHUNK_W'(first_val + j));
  endtask

  // Called at a negedge with inputs applied: check outputs, advance model, move to next negedge.
  task automatic step();
    logic [LANES-1:0] mask;
    logic             exp_err;
    bit               fire, idle, hs;
    logic [DW-1:0]    w;
    #1;
    mask = lane_mask(m_lanes);
    fire = (!m_out_valid || i_0_ack) && ((t_req & mask) == mask);
    idle = (m_count == 0) && !m_out_valid;
    hs   = t_cfg_req && idle;
`ifdef DEFUNNEL_ERR_EN
    exp_err = m_err;
`else
    exp_err = 1'b0;
`endif
    check("t_ack", DW'(t_ack), DW'(fire ? mask : '0));
    check("t_cfg_ack", DW'(t_cfg_ack), DW'(idle));
    check("i_0_req", DW'(i_0_req), DW'(m_out_valid));
    if (m_out_valid && exp_q.size() > 0) check("i_0_dat", i_0_dat, exp_q[0]);
    check("state", DW'(dbg_state_o), DW'(m_count));
    check("reduct", DW'(dbg_reduct_o), DW'(m_lanes));
    check("err", DW'(err), DW'(exp_err));

    if (m_out_valid && i_0_ack) begin
      void'(exp_q.pop_front());
      m_out_valid = 0;
    end
    if ((t_req & ~mask) != '0) m_err = 1;
    if (fire) begin
      for (int j = 0; j < m_lanes; j++) m_chunks[m_count + j] = t_dat[j*CHUNK_W +: CHUNK_W];
      m_count += m_lanes;
      if (m_count == CHUNKS) begin
        for (int n = 0; n < CHUNKS; n++) w[n*CHUNK_W +: CHUNK_W] = m_chunks[n];
        exp_q.push_back(w);
        m_out_valid = 1;
        m_count = 0;
      end
    end
    if (hs) begin
      if (legal_mode(mode)) m_lanes = int'(mode[STEPS-1:0]);
      else m_err = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic config_step(input logic [7:0] md);
    t_req = '0;
    t_cfg_req = 1'b1;
    mode = md;
    step();
    t_cfg_req = 1'b0;
  endtask

  initial begin
    t_req = '0; t_dat = '0; t_cfg_req = 1'b0; mode = 8'h00; i_0_ack = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_i_0_req", DW'(i_0_req), '0);
    check("rst_i_0_dat", i_0_dat, '0);
    check("rst_t_ack", DW'(t_ack), '0);
    check("rst_cfg_ack", DW'(t_cfg_ack), DW'(1));
    check("rst_state", DW'(dbg_state_o), '0);
    check("rst_reduct", DW'(dbg_reduct_o), DW'(4));
    check("rst_err", DW'(err), '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 8:4 default, two words back to back
    i_0_ack = 1'b1;
    set_beat(4'hf, 0); step();
    set_beat(4'hf, 4); step();
    #1 check("w84_dat", i_0_dat, seq_word());
    set_beat(4'hf, 8); step();
    set_beat(4'hf, 12); step();
    set_beat(4'h0, 0); step();
    step();

    // 8:1
    config_step(8'h01);
    for (int b = 0; b < 8; b++) begin
      set_beat(4'b0001, b); step();
    end
    #1 check("w81_dat", i_0_dat, seq_word());
    set_beat(4'h0, 0); step();

    // 8:2 with backpressure, then refill in the ack cycle
    config_step(8'h02);
    i_0_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      set_beat(4'b0011, 2*b); step();
    end
    for (int k = 0; k < 3; k++) begin
      set_beat(4'b0011, 100 + k); step();
      #1 check("bp_hold_dat", i_0_dat, seq_word());
    end
    i_0_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_beat(4'b0011, 200 + 2*b); step();
    end
    set_beat(4'h0, 0); step();

    // partial lanes and config gating in 8:4
    config_step(8'h04);
    set_beat(4'b0111, 0); step();
    step();
    set_beat(4'hf, 0); step();
    t_cfg_req = 1'b1; mode = 8'h01;
    t_req = '0; step();
    i_0_ack = 1'b0;
    set_beat(4'hf, 4); step();
    t_req = '0; step();
    i_0_ack = 1'b1; step();
    step();
    mode = 8'h03; step();
    mode = 8'h04; step();
    t_cfg_req = 1'b0;

    // reset mid-word
    set_beat(4'hf, 0); step();
    reset_n = 1'b0;
    t_req = '0;
    #1;
    check("mid_rst_req", DW'(i_0_req), '0);
    check("mid_rst_state", DW'(dbg_state_o), '0);
    check("mid_rst_reduct", DW'(dbg_reduct_o), DW'(4));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_beat(4'hf, 0); step();
    set_beat(4'hf, 4); step();
    #1 check("post_rst_dat", i_0_dat, seq_word());
    t_req = '0; step();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      int r;
      logic [7:0] modes[6];
      modes[0] = 8'h01; modes[1] = 8'h02; modes[2] = 8'h04;
      modes[3] = 8'h03; modes[4] = 8'h00; modes[5] = 8'h82;
      for (int j = 0; j < LANES; j++) set_lane(j, {$urandom, $urandom, $urandom, $urandom});
      i_0_ack = ($urandom_range(0, 3) != 0);
      t_cfg_req = 1'b0;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        t_req = '0;
        t_cfg_req = 1'b1;
        mode = modes[$urandom_range(0, 5)];
      end else if (r < 13) begin
        t_req = lane_mask(m_lanes);
      end else if (r < 19) begin
        t_req = '0;
      end else begin
        t_req = LANES'($urandom_range(0, 15));
      end
      step();
    end
    t_req = '0; t_cfg_req = 1'b0; i_0_ack = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
